// File: rtl/cgol_pkg.sv
// Shared types and constants for the Game of Life board loader.
package cgol_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROWS  = 3'd1,
        CSUM  = 3'd2,
        REQ   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } loader_state_t;

    // Default frame header byte
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Default row address width and resulting frame length (header + rows + checksum)
    localparam int unsigned REGBITS_DEFAULT = 3;
    localparam int unsigned FRAME_LEN       = (1 << REGBITS_DEFAULT) + 2;

    // Frame length for an arbitrary row address width
    function automatic int unsigned frame_len(input int unsigned regbits);
        return (1 << regbits) + 2;
    endfunction

endpackage

// File: rtl/loader_rowbuf.sv
// Row buffer: holds one received frame until it is committed to the state file.
module loader_rowbuf
    import cgol_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REGBITS = 3
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               i_we,
    input  logic [REGBITS-1:0] i_widx,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [REGBITS-1:0] i_ridx,
    output logic [WIDTH-1:0]   o_rdata
);

    localparam int unsigned DEPTH = 1 << REGBITS;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage array with a single write port
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    // Combinational read port
    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/board_loader.sv
// Framed byte-stream loader that checks a board pattern and writes it into the state file.
module board_loader
    import cgol_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REGBITS = 3,
    parameter logic [WIDTH-1:0] SYNC = WIDTH'(SYNC_DEFAULT),
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               hold,
    input  logic               hold_ack,
    output logic               wr_en,
    output logic [REGBITS-1:0] wr_addr,
    output logic [WIDTH-1:0]   wr_data,
    output logic               done,
    output logic               err
);

    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [REGBITS-1:0] LAST_ROW = '1;

    loader_state_t      r_state;
    logic [REGBITS-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [TMO_W-1:0]   r_tmo;

    logic               w_xfer;
    logic               w_tmo_hit;
    logic [REGBITS-1:0] w_cnt_inc;
    logic [REGBITS-1:0] w_rd_idx;
    logic [WIDTH-1:0]   w_rd_data;
    logic               w_buf_we;

    // Byte handshake and counter helpers
    assign in_ready  = (r_state == IDLE) || (r_state == ROWS) || (r_state == CSUM);
    assign w_xfer    = in_valid && in_ready;
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_cnt_inc = REGBITS'(r_cnt + 1'b1);
    assign w_buf_we  = w_xfer && (r_state == ROWS);
    // REQ preloads row 0; WRITE looks one row ahead of the row being driven out
    assign w_rd_idx  = (r_state == WRITE) ? w_cnt_inc : '0;

    loader_rowbuf #(
        .WIDTH   (WIDTH),
        .REGBITS (REGBITS)
    ) u_rowbuf (
        .ph1     (ph1),
        .reset   (reset),
        .i_we    (w_buf_we),
        .i_widx  (r_cnt),
        .i_wdata (in_data),
        .i_ridx  (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    // Loader FSM with registered outputs
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_tmo   <= '0;
            hold    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer && (in_data == SYNC)) begin
                        r_state <= ROWS;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_tmo   <= '0;
                    end
                end
                ROWS: begin
                    if (w_xfer) begin
                        r_acc <= r_acc ^ in_data;
                        r_tmo <= '0;
                        if (r_cnt == LAST_ROW) begin
                            r_state <= CSUM;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else if (w_tmo_hit) begin
                        err     <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= TMO_W'(r_tmo + 1'b1);
                    end
                end
                CSUM: begin
                    if (w_xfer) begin
                        r_tmo <= '0;
                        if (in_data == r_acc) begin
                            r_state <= REQ;
                            hold    <= 1'b1;
                        end else begin
                            err     <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else if (w_tmo_hit) begin
                        err     <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= TMO_W'(r_tmo + 1'b1);
                    end
                end
                REQ: begin
                    if (hold_ack) begin
                        r_state <= WRITE;
                        r_cnt   <= '0;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= w_rd_data;
                    end
                end
                WRITE: begin
                    // hold_ack is not rechecked: once started, the commit runs to completion
                    if (r_cnt == LAST_ROW) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        wr_en   <= 1'b0;
                        wr_addr <= '0;
                        wr_data <= '0;
                        hold    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        wr_addr <= w_cnt_inc;
                        wr_data <= w_rd_data;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/board_loader.md
# board_loader

Serial-to-register-file loader that brings an initial Game of Life pattern into the 8x8 board state. It is the inbound counterpart of the display path: dispcontrol scans state out to the LED matrix, and board_loader takes a framed byte stream in, checks it, and writes it row by row into the current-state storage. While it writes, it holds the generation controller off through a hold/ack handshake.

## Interface
Parameters:
- WIDTH, 8, row width in cells and width of the data byte
- REGBITS, 3, row address width (2^REGBITS rows)
- SYNC, 8'hA5, frame header byte
- TIMEOUT, 255, idle cycles allowed between bytes inside a frame

Ports:
- ph1  input  1  the single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- in_valid  input  1  a byte is presented on in_data
- in_data  input  WIDTH  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- hold  output  1  request that the generation controller freeze and release the state file
- hold_ack  input  1  controller grants the state file
- wr_en  output  1  state-file write strobe
- wr_addr  output  REGBITS  row being written
- wr_data  output  WIDTH  row contents
- done  output  1  one-cycle pulse when a frame has been committed
- err  output  1  one-cycle pulse on checksum mismatch or timeout

## Operation
- Frame format: SYNC, then 2^REGBITS row bytes (row 0 first), then a checksum byte equal to the XOR of all row bytes.
- A byte transfers on a rising edge where in_valid and in_ready are both 1.
- FSM states:
  - IDLE: in_ready=1. A byte equal to SYNC goes to ROWS with row count cleared. Any other byte is consumed and discarded.
  - ROWS: in_ready=1. Each byte goes into the row buffer at the current count, and the XOR accumulator updates. After the 8th row, go to CSUM.
  - CSUM: in_ready=1. If the byte equals the accumulator, go to REQ. Otherwise pulse err and return to IDLE with no writes.
  - REQ: in_ready=0, hold=1. Stay until hold_ack is sampled 1, then go to WRITE with addr=0.
  - WRITE: in_ready=0, hold=1, wr_en=1, wr_addr=count, wr_data=buffer[count]. After 8 cycles go to DONE.
  - DONE: hold=0, done=1 for one cycle, then IDLE.
- Timeout: in ROWS or CSUM, TIMEOUT consecutive cycles with no transfer pulse err and return to IDLE. The counter restarts on every transfer.
- hold_ack dropping during WRITE is ignored; the write completes.
- A SYNC value arriving as a row or checksum byte is data, not a resync.
- The accumulator and the row count wrap only through explicit clear on SYNC. Neither is ever read out of range.

## Timing
- Reset values: hold, wr_en, done, err, wr_addr and wr_data are all 0; state is IDLE.
  - in_ready is decoded from state, so it reads 1 while reset is low.
- Registered outputs: hold, wr_en, wr_addr, wr_data, done, err.
- Checksum accepted at edge N gives hold=1 after edge N.
- hold_ack sampled 1 at edge M gives wr_en=1 with addresses 0..7 in the cycles after edges M..M+7.
- After edge M+8: wr_en=0, hold=0, done=1. After edge M+9: done=0 and in_ready=1.
- Best-case frame-to-commit: 10 byte cycles, +1 REQ cycle, +8 writes, +1 DONE.
- err is high for exactly one cycle. in_ready is 1 in that same cycle because the FSM is already back in IDLE.
- Reset mid-WRITE: outputs clear asynchronously. Rows already written stay in the state file, and the frame is lost.

## Structure
- cgol_pkg holds:
  - the loader state enum (IDLE, ROWS, CSUM, REQ, WRITE, DONE)
  - the SYNC default
  - the frame length constant (2^REGBITS + 2)
- One sub-module, loader_rowbuf: a 2^REGBITS x WIDTH register array with a write port (index, data, enable) and a combinational read port. It is reset to 0.
- Counters (row/write index, timeout) and the XOR accumulator live in board_loader.

## Test plan
- Glider frame A5,40,20,E0,00,00,00,00,00,80 with hold_ack tied 1: writes rows 0..7 = 40,20,E0,00,00,00,00,00; done pulses once; err stays 0.
- Same frame with checksum 81: err pulses one cycle after the last byte; wr_en and hold are never asserted; the next valid frame commits normally.
- Leading garbage 00,FF,3C, then the glider frame: the garbage is consumed with no effect; commit is identical to the first scenario.
- hold_ack held 0 for 20 cycles after the checksum: hold stays 1, wr_en stays 0, and in_ready stays 0; the first write appears the cycle after ack.
- With TIMEOUT=4, stall in_valid for 4 cycles after the 3rd row byte: err pulses and the FSM returns to IDLE. A stall of 3 cycles instead resumes the frame without error.
- Assert reset after the 3rd write cycle: all outputs are 0 immediately. After release, in_ready=1 and a full frame reloads correctly.
